seq_signed_divider: RTL and testbench

- Multi-cycle signed divider. It is the inverse operation of the team's 8x8 two's-complement array/Wallace multiplier: a 16-bit product-width dividend divided by an 8-bit divisor gives an 8-bit quotient and an 8-bit remainder.
- Radix-2 restoring algorithm on magnitudes, one quotient bit per clock, with sign fix-up at the end.
- Sits beside the multiplier in the arithmetic unit and uses a start/busy/done handshake.

---
 rtl/seq_signed_divider.sv | 129 ++++++++++++
 tb/tb_seq_signed_divider.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: 16-bit dividend / 8-bit divisor -> 8-bit quotient and remainder.
// Radix-2 restoring division on magnitudes (one quotient bit per clock), then a sign fix-up cycle.
module seq_signed_divider #(
  parameter int DW = 16,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [QW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient,
  output logic [QW-1:0] remainder,
  output logic          ovf,
  output logic          dz
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t        state, state_next;
  logic [3:0]    count;
  logic [DW-1:0] dvd;
  logic [QW-1:0] dvs;
  logic [QW:0]   prem;
  logic          sign_q, sign_r;

  logic [DW-1:0] abs_dividend;
  logic [QW-1:0] abs_divisor;
  logic [QW+1:0] shifted, diff;
  logic          q_bit;
  logic [DW:0]   q_signed;
  logic [QW-1:0] r_signed;
  logic          q_fits;

  // dvd doubles as the quotient register: dividend bits leave at the top while quotient bits enter at the bottom.
  always_comb begin
    abs_dividend = dividend[DW-1] ? -dividend : dividend;
    abs_divisor  = divisor[QW-1]  ? -divisor  : divisor;
    shifted      = {prem, dvd[DW-1]};
    diff         = shifted - {2'b00, dvs};
    q_bit        = ~diff[QW+1];
    q_signed     = sign_q ? -{1'b0, dvd} : {1'b0, dvd};
    r_signed     = sign_r ? -prem[QW-1:0] : prem[QW-1:0];
    q_fits       = (&q_signed[DW:QW-1]) | ~(|q_signed[DW:QW-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count == 4'd0) begin
          state_next = FIX;
        end
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      dvd       <= '0;
      dvs       <= '0;
      prem      <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dz        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dz        <= (divisor == '0);
            sign_q    <= dividend[DW-1] ^ divisor[QW-1];
            sign_r    <= dividend[DW-1];
            dvd       <= abs_dividend;
            dvs       <= abs_divisor;
            prem      <= '0;
            count     <= 4'd15;
          end
        end
        CALC: begin
          prem  <= q_bit ? diff[QW:0] : shifted[QW:0];
          dvd   <= {dvd[DW-2:0], q_bit};
          count <= count - 4'd1;
        end
        FIX: begin
          // The low byte is reported even when the true quotient does not fit.
          quotient  <= q_signed[QW-1:0];
          remainder <= r_signed;
          ovf       <= ~q_fits;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Scoreboard bench for seq_signed_divider: directed cases, handshake/reset scenarios and random operands
// checked against C-style integer division computed in the bench.
module tb_seq_signed_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done, ovf, dz;
  logic [7:0]  quotient, remainder;

  typedef struct packed {
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;
    logic [31:0] due;
  } exp_t;

  exp_t exp_q[$];
  int   cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   busy_lo = 1;
  int   busy_hi = 0;

  seq_signed_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Reference: plain signed integer division, which truncates toward zero with the remainder taking the dividend's sign.
  function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input int due);
    exp_t e;
    int   sa, sb, q, r;
    sa    = int'($signed(a));
    sb    = int'($signed(b));
    e.due = due;
    if (sb == 0) begin
      e.q = 8'h00; e.r = 8'h00; e.ovf = 1'b0; e.dz = 1'b1;
    end else begin
      q     = sa / sb;
      r     = sa % sb;
      e.q   = q[7:0];
      e.r   = r[7:0];
      e.ovf = (q > 127) || (q < -128);
      e.dz  = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    checkOutput("busy", {31'd0, busy}, {31'd0, (cycle >= busy_lo) && (cycle <= busy_hi)});
    if (done) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("done_cycle", cycle, e.due);
        checkOutput("quotient", {24'd0, quotient}, {24'd0, e.q});
        checkOutput("remainder", {24'd0, remainder}, {24'd0, e.r});
        checkOutput("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        checkOutput("dz", {31'd0, dz}, {31'd0, e.dz});
      end
    end
  end

  // Starts one operation while the DUT is idle; acc returns the acceptance cycle.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b, output int acc);
    @(posedge clk);
    #1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    acc      = cycle;
    exp_q.push_back(model(a, b, acc + ((b == 8'h00) ? 1 : 18)));
    if (b != 8'h00) begin
      busy_lo = acc + 1;
      busy_hi = acc + 17;
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic waitDone(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    checkOutput("done_timeout", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic waitUntil(input int c);
    while (cycle < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runOne(input logic [15:0] a, input logic [7:0] b);
    int acc;
    applyStimulus(a, b, acc);
    waitDone(40);
  endtask

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          n;
    logic [15:0] a;
    logic [7:0]  b;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_quotient", {24'd0, quotient}, 32'd0);
    checkOutput("reset_remainder", {24'd0, remainder}, 32'd0);
    checkOutput("reset_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("reset_dz", {31'd0, dz}, 32'd0);
    rst_n = 1'b1;

    runOne(16'hFC00, 8'h80);
    runOne(16'hFF9C, 8'h07);
    runOne(16'h0064, 8'hF9);
    runOne(16'h03E8, 8'h07);
    runOne(16'h8000, 8'h80);
    runOne(16'h1234, 8'h00);
    runOne(16'h7FFF, 8'hFF);
    runOne(16'h8000, 8'h01);

    $display("[TB] handshake: ignored start and held start");
    applyStimulus(16'hFF9C, 8'h07, n);
    waitUntil(n + 5);
    dividend = 16'h4000;
    divisor  = 8'h03;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitUntil(n + 18);
    dividend = 16'h0BB8;
    divisor  = 8'hE7;
    start    = 1'b1;
    exp_q.push_back(model(16'h0BB8, 8'hE7, n + 37));
    busy_lo = n + 20;
    busy_hi = n + 36;
    waitUntil(n + 20);
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    waitDone(40);

    $display("[TB] reset during a division");
    applyStimulus(16'h1000, 8'h03, n);
    waitUntil(n + 9);
    rst_n = 1'b0;
    exp_q.delete();
    busy_lo = 1;
    busy_hi = 0;
    #1;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    checkOutput("abort_quotient", {24'd0, quotient}, 32'd0);
    checkOutput("abort_remainder", {24'd0, remainder}, 32'd0);
    checkOutput("abort_ovf", {31'd0, ovf}, 32'd0);
    checkOutput("abort_dz", {31'd0, dz}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    runOne(16'h007F, 8'h01);

    $display("[TB] random operands");
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 16'h8000;
        1:       a = 16'h7FFF;
        default: a = 16'($urandom);
      endcase
      case ($urandom_range(0, 11))
        0:       b = 8'h01;
        1:       b = 8'hFF;
        2:       b = 8'h80;
        3:       b = 8'h00;
        default: b = 8'($urandom);
      endcase
      runOne(a, b);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
